// File: rtl/apb_master_bridge_n.sv
// apb_master_bridge_n: valid/ready command port to an APB3 master with one-hot slot decode.
// Latency: accept at edge N -> PSEL N+1, PENABLE N+2, RSP_VALID N+3, plus one cycle per PREADY wait.
// Backpressure: one transfer in flight; CMD_READY only in IDLE, response held until RSP_READY.
module apb_master_bridge_n #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 16,
  parameter int SLOT_LSB       = 8,
  parameter int SLOT_BITS      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  SYSCLK,
  input  logic                  SYSRST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Counter holds 0..TIMEOUT_CYCLES and saturates, so it can never wrap.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Value seen during the last allowed ACCESS cycle (counter cleared on SETUP entry).
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [SLOT_BITS-1:0]  cmd_slot;
  logic                  slot_ok;
  logic                  cmd_fire;

  // Slot field decode and command handshake
  always_comb begin
    cmd_slot  = CMD_ADDR[SLOT_LSB +: SLOT_BITS];
    slot_ok   = (32'(cmd_slot) < NUM_SLAVES);
    CMD_READY = (state_q == ST_IDLE) && !SYSRST;
    cmd_fire  = CMD_VALID && CMD_READY;
  end

  // Next-state and next-output computation for the transfer sequencer
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          paddr_d  = CMD_ADDR;
          pwrite_d = CMD_WRITE;
          pwdata_d = CMD_WDATA;
          if (slot_ok) begin
            state_d   = ST_SETUP;
            psel_d    = NUM_SLAVES'(1) << cmd_slot;
            penable_d = 1'b0;
            cnt_d     = '0;
          end else begin
            // Unmapped slot: answer with an error without touching the bus.
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // PREADY takes priority over a timeout landing in the same cycle.
        if (PREADY) begin
          state_d       = ST_RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (pwrite_q || PSLVERR) ? '0 : PRDATA;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d       = ST_RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end
      end

      ST_RESP: begin
        if (RSP_READY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any transfer silently
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Registered outputs drive the ports directly
  always_comb begin
    PADDR       = paddr_q;
    PSEL        = psel_q;
    PENABLE     = penable_q;
    PWRITE      = pwrite_q;
    PWDATA      = pwdata_q;
    RSP_VALID   = rsp_valid_q;
    RSP_RDATA   = rsp_rdata_q;
    RSP_ERR     = rsp_err_q;
    RSP_TIMEOUT = rsp_timeout_q;
  end

endmodule
